// File: rtl/adder_sched_pkg.sv
// Shared types, defaults and the round-robin pick function for the
// adder scheduler.
package adder_sched_pkg;

    localparam int N_DEF    = 8;
    localparam int NREQ_DEF = 4;
    localparam int CNTW_DEF = 16;
    localparam int RR_MAX   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First valid index at or after ptr, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [3:0]        ptr,
                                         input int unsigned       nreq);
        rr_pick_t   r;
        logic [4:0] j;
        r = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            j = 5'({1'b0, ptr}) + 5'(k);
            if (j >= 5'(nreq)) j = j - 5'(nreq);
            if (k < int'(nreq) && !r.found && valid[j[3:0]]) begin
                r.found = 1'b1;
                r.idx   = j[3:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_sched_if.sv
// Request/response bundle between client datapaths (master) and the
// adder scheduler (slave).
interface adder_sched_if
    import adder_sched_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_sum;
    logic              rsp_carry;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );
endinterface

// File: rtl/adder_sched_seq_adder.sv
// Registered N-bit adder: {carry_o, sum_o} holds a_i + b_i from the
// previous clock edge.
module seq_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o,
    output logic         carry_o
);
    logic [N:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= {1'b0, a_i} + {1'b0, b_i};
    end

    assign {carry_o, sum_o} = sum_q;
endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one seq_adder among NREQ requesters;
// results return tagged with the owning requester index.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    adder_sched_if.slave    bus,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);
    sched_state_t    state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  rr_ptr_d;
    logic [IDW-1:0]  rsp_id_q;
    logic [N-1:0]    op_a_q;
    logic [N-1:0]    op_b_q;
    logic [CNTW-1:0] op_count_q;

    rr_pick_t        pick;
    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [N-1:0]    grant_a;
    logic [N-1:0]    grant_b;
    logic [NREQ-1:0] req_ready;
    logic [N-1:0]    sum;
    logic            carry;

    always_comb begin
        pick      = rr_pick(16'(bus.req_valid), 4'(rr_ptr_q), NREQ);
        grant_vld = pick.found && (state_q == IDLE);
        grant_idx = IDW'(pick.idx);
        grant_a   = bus.req_a[grant_idx*N +: N];
        grant_b   = bus.req_b[grant_idx*N +: N];
        rr_ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        req_ready = '0;
        if (grant_vld) req_ready[grant_idx] = 1'b1;
    end

    // Operands stay latched through RESP so the adder output is stable
    // for as long as the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            rsp_id_q   <= '0;
            op_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        op_a_q   <= grant_a;
                        op_b_q   <= grant_b;
                        rsp_id_q <= grant_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= EXEC;
                    end
                end
                EXEC: state_q <= RESP;
                RESP: begin
                    if (bus.rsp_ready) begin
                        op_count_q <= op_count_q + 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    seq_adder #(.N(N)) u_adder (
        .clk     (clk),
        .rst     (rst),
        .a_i     (op_a_q),
        .b_i     (op_b_q),
        .sum_o   (sum),
        .carry_o (carry)
    );

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = sum;
    assign bus.rsp_carry = carry;
    assign busy          = (state_q != IDLE);
    assign op_count      = op_count_q;
endmodule

// File: tb/tb_adder_sched.sv
// Directed and random-soak bench for adder_sched with a 4-bit counter so
// the op_count wrap is reachable quickly.
module tb_adder_sched;
    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic [CNTW-1:0] op_count;

    always #5 clk = ~clk;

    adder_sched_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

    adder_sched #(.N(N), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    int n_vec   = 0;
    int n_err   = 0;
    int exp_ptr = 0;
    int exp_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic do_reset;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        tick;
        tick;
        rst     = 1'b0;
        exp_ptr = 0;
        exp_cnt = 0;
        #1;
    endtask

    // One IDLE->EXEC->RESP pass; stall = RESP cycles with rsp_ready low,
    // keep = leave req_valid asserted after the grant.
    task automatic run_op(input logic [NREQ-1:0] vld, input logic [NREQ*N-1:0] pa,
                          input logic [NREQ*N-1:0] pb, input int stall, input bit keep);
        int         g;
        logic [N:0] s;
        bus.req_valid = vld;
        bus.req_a     = pa;
        bus.req_b     = pb;
        bus.rsp_ready = 1'b0;
        #1;
        g = model_grant(vld);
        if (g < 0) begin
            check_val("idle_no_ready", 32'(bus.req_ready), 32'd0);
            tick;
            check_val("idle_busy", 32'(busy), 32'd0);
            return;
        end
        check_val("grant", 32'(bus.req_ready), 32'(1 << g));
        s       = {1'b0, pa[g*N +: N]} + {1'b0, pb[g*N +: N]};
        exp_ptr = (g + 1) % NREQ;
        tick;
        if (!keep) bus.req_valid = '0;
        #1;
        check_val("exec_busy", 32'(busy), 32'd1);
        check_val("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("exec_ready", 32'(bus.req_ready), 32'd0);
        tick;
        for (int i = 0; i < stall; i++) begin
            check_val("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check_val("stall_id", 32'(bus.rsp_id), 32'(g));
            check_val("stall_sum", 32'({bus.rsp_carry, bus.rsp_sum}), 32'(s));
            check_val("stall_ready", 32'(bus.req_ready), 32'd0);
            tick;
        end
        bus.rsp_ready = 1'b1;
        #1;
        check_val("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_val("rsp_id", 32'(g), 32'(bus.rsp_id));
        check_val("rsp_sum", 32'({bus.rsp_carry, bus.rsp_sum}), 32'(s));
        tick;
        bus.rsp_ready = 1'b0;
        exp_cnt++;
        check_val("op_count", 32'(op_count), 32'(exp_cnt % (1 << CNTW)));
        check_val("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        do_reset;
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_op_count", 32'(op_count), 32'd0);

        // single request on requester 2: 100 + 27
        run_op(4'b0100, {8'd0, 8'd100, 8'd0, 8'd0}, {8'd0, 8'd27, 8'd0, 8'd0}, 0, 1'b0);
        // carry boundary on requester 0, pointer wraps from 3
        run_op(4'b0001, {24'd0, 8'd255}, {24'd0, 8'd255}, 0, 1'b0);
        run_op(4'b0001, 32'd0, 32'd0, 0, 1'b0);

        // round robin with all requesters held valid: sums 0,11,22,33,0
        do_reset;
        for (int i = 0; i < 5; i++)
            run_op(4'b1111, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd30, 8'd20, 8'd10, 8'd0}, 0, 1'b1);

        // backpressure on requester 1 while requester 3 waits
        run_op(4'b1010, {8'd7, 8'd0, 8'd5, 8'd0}, {8'd8, 8'd0, 8'd6, 8'd0}, 5, 1'b1);
        run_op(4'b1000, {8'd7, 8'd0, 8'd5, 8'd0}, {8'd8, 8'd0, 8'd6, 8'd0}, 0, 1'b0);

        // reset during EXEC discards the in-flight result
        bus.req_valid = 4'b0100;
        bus.req_a     = {8'd0, 8'd1, 16'd0};
        bus.req_b     = {8'd0, 8'd2, 16'd0};
        #1;
        check_val("mid_grant", 32'(bus.req_ready), 32'b0100);
        tick;
        bus.req_valid = '0;
        rst           = 1'b1;
        tick;
        rst     = 1'b0;
        exp_ptr = 0;
        exp_cnt = 0;
        #1;
        check_val("mid_busy", 32'(busy), 32'd0);
        check_val("mid_count", 32'(op_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_val("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
            tick;
        end
        run_op(4'b1010, {8'd9, 8'd0, 8'd4, 8'd0}, {8'd1, 8'd0, 8'd3, 8'd0}, 0, 1'b0);

        // counter wrap: 16 completions on a 4-bit counter
        do_reset;
        for (int i = 0; i < 15; i++)
            run_op(4'(1 << (i % NREQ)), 32'hFFFF_FFFF, 32'(i), 0, 1'b0);
        check_val("pre_wrap", 32'(op_count), 32'd15);
        run_op(4'b0010, 32'h0000_8000, 32'h0000_8000, 0, 1'b0);
        check_val("wrap", 32'(op_count), 32'd0);

        // random soak
        for (int i = 0; i < 10000; i++)
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom,
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
